// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
// Contents: FSM state encoding, per-scan raw result encoding, matrix size,
// KEY_MAP lookup indexed by {row, col}, and a small population-count helper.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RAW_NONE   = 2'd0,
    RAW_SINGLE = 2'd1,
    RAW_MULTI  = 2'd2
  } raw_e;

  // Index is {row[1:0], col[1:0]}; entry 15 is listed first.
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: 0 F E D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [2:0] count_ones(input logic [NUM_ROWS-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - two-flop synchronizer for the active-low keypad rows
// Ports:
//   clk      in  system clock
//   rst_L    in  asynchronous active-low reset (flops reset to all-ones = no key)
//   async_i  in  asynchronous row inputs
//   sync_o   out synchronized row inputs
module keypad_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst_L,
  input  logic [NUM_ROWS-1:0] async_i,
  output logic [NUM_ROWS-1:0] sync_o
);

  logic [NUM_ROWS-1:0] meta_q;
  logic [NUM_ROWS-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and press strobe
// Ports:
//   clk        in   system clock
//   rst_L      in   asynchronous active-low reset
//   row_L      in   [3:0] keypad rows, active low, asynchronous; bit0 = top row
//   col_L      out  [3:0] one-hot-low column drive; bit0 = left column
//   key_code   out  [3:0] hex code of the last accepted key
//   key_valid  out  one-cycle pulse when a new press is accepted
//   key_held   out  high while the accepted key is considered down
//   digits     out  [15:0] last four accepted keys, newest in [3:0]
// Build option: KEYPAD_SHIFT_EN adds the four-digit shift register behind
// digits; without it digits = {12'b0, key_code}.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic [3:0]  row_L,
  output logic [3:0]  col_L,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int              DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_TARGET = 4'(DEBOUNCE_SCANS);

  // ---------------------------------------------------------------- timing
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic             sample;
  logic             scan_end;

  assign sample   = (div_q == DIV_LAST);
  assign scan_end = sample && (col_q == 2'(NUM_COLS - 1));
  assign div_d    = sample ? '0 : div_q + 1'b1;
  assign col_d    = sample ? col_q + 2'd1 : col_q;
  assign col_L    = ~(4'b0001 << col_q);

  // -------------------------------------------------------- row sampling
  logic [NUM_ROWS-1:0] row_sync;

  keypad_sync u_sync (
    .clk     (clk),
    .rst_L   (rst_L),
    .async_i (row_L),
    .sync_o  (row_sync)
  );

  // Accumulated key count for the current scan saturates at 2 (= MULTI);
  // the code is only meaningful while the count is exactly 1.
  logic [1:0] acc_cnt_q, acc_cnt_d;
  logic [3:0] acc_code_q, acc_code_d;
  logic [1:0] scan_cnt;
  logic [3:0] scan_code;
  logic [2:0] n_rows;
  logic [1:0] row_idx;
  raw_e       raw;

  assign n_rows = count_ones(~row_sync);

  always_comb begin
    row_idx = 2'd0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!row_sync[r]) row_idx = 2'(r);
    end
  end

  // scan_cnt/scan_code include the column being sampled this cycle, so the
  // FSM sees the complete scan on the col 3 sample cycle.
  always_comb begin
    scan_cnt   = acc_cnt_q;
    scan_code  = acc_code_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      if (n_rows != 3'd0) begin
        if (acc_cnt_q == 2'd0 && n_rows == 3'd1) begin
          scan_cnt  = 2'd1;
          scan_code = KEY_MAP[{row_idx, col_q}];
        end else begin
          scan_cnt  = 2'd2;
        end
      end
      acc_cnt_d  = scan_end ? 2'd0 : scan_cnt;
      acc_code_d = scan_code;
    end
  end

  always_comb begin
    unique case (scan_cnt)
      2'd0:    raw = RAW_NONE;
      2'd1:    raw = RAW_SINGLE;
      default: raw = RAW_MULTI;
    endcase
  end

  // ------------------------------------------------------------------- FSM
  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       single;

  // MULTI is deliberately folded into "no key" so ghosted combinations
  // never start or sustain a press.
  assign single = (raw == RAW_SINGLE);

`ifdef KEYPAD_SHIFT_EN
  logic [15:0] digits_q, digits_d;
`endif

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_SHIFT_EN
    digits_d    = digits_q;
`endif
    if (scan_end) begin
      unique case (state_q)
        IDLE: begin
          if (single) begin
            cand_d = scan_code;
            cnt_d  = 4'd1;
            if (DEBOUNCE_SCANS == 1) begin
              state_d     = HELD;
              key_code_d  = scan_code;
              key_valid_d = 1'b1;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (single && scan_code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DB_TARGET) begin
              state_d     = HELD;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (!single) begin
            cnt_d   = 4'd1;
            state_d = (DEBOUNCE_SCANS == 1) ? IDLE : REL_DB;
          end
        end
        REL_DB: begin
          if (single) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DB_TARGET) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef KEYPAD_SHIFT_EN
    if (key_valid_d) digits_d = {digits_q[11:0], key_code_d};
`endif
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      div_q       <= '0;
      col_q       <= 2'd0;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

`ifdef KEYPAD_SHIFT_EN
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) digits_q <= 16'h0000;
    else        digits_q <= digits_d;
  end
  assign digits = digits_q;
`else
  assign digits = {12'h000, key_code_q};
`endif

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == HELD) || (state_q == REL_DB);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a keypad model driven from col_L
module tb_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DB       = 3;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic [3:0]  row_L;
  logic [3:0]  col_L;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  // keys_down bit index = row*4 + col
  logic [15:0] keys_down = 16'h0000;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .row_L     (row_L),
    .col_L     (col_L),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digits    (digits)
  );

  // Physical keypad: a row reads low when any pressed key on it sits in the driven column.
  always_comb begin
    row_L = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_down[r*4+c] && !col_L[c]) row_L[r] = 1'b0;
      end
    end
  end

  logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'h0, 4'hF, 4'hE, 4'hD};

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] dig;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: accepted/held flag, length of the current run of
  // matching single-key scans, and length of the current run of non-single scans.
  bit          m_held     = 1'b0;
  int          m_run_len  = 0;
  int          m_quiet    = 0;
  logic [3:0]  m_run_code = 4'h0;
  logic [3:0]  m_code     = 4'h0;
  logic [15:0] m_digits   = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_run_len = 0; m_quiet = 0;
    m_run_code = 4'h0; m_code = 4'h0; m_digits = 16'h0000;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [3:0] c);
    exp_t e;
    m_held  = 1'b1;
    m_quiet = 0;
    m_code  = c;
`ifdef KEYPAD_SHIFT_EN
    m_digits = {m_digits[11:0], c};
`else
    m_digits = {12'h000, c};
`endif
    e.code = c;
    e.dig  = m_digits;
    exp_q.push_back(e);
  endtask

  task automatic model_scan(input logic [15:0] keys);
    bit         single;
    logic [3:0] c;
    single = ($countones(keys) == 1);
    c = 4'h0;
    for (int i = 0; i < 16; i++) if (keys[i]) c = key_map[i];
    if (!m_held) begin
      if (single) begin
        if (m_run_len > 0 && c != m_run_code) begin
          m_run_len = 0;
        end else begin
          m_run_code = c;
          m_run_len++;
          if (m_run_len == DB) model_accept(c);
        end
      end else begin
        m_run_len = 0;
      end
    end else begin
      if (single) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == DB) begin
          m_held = 1'b0;
          m_run_len = 0;
        end
      end
    end
  endtask

  // Holds the given keys for one full scan; called right after a scan boundary.
  task automatic run_scan(input logic [15:0] keys);
    int n;
    keys_down = keys;
    n = 0;
    while (col_L !== 4'b0111 && n < 64) begin @(posedge clk); #1; n++; end
    while (col_L !== 4'b1110 && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) begin
      checks++; errors++;
      $display("FAIL scan_timeout actual=%h expected=scan boundary", col_L);
    end
    model_scan(keys);
    check("key_held", {31'b0, key_held}, {31'b0, m_held});
  endtask

  task automatic press_release(input int idx);
    repeat (DB) run_scan(16'h0001 << idx);
    repeat (DB) run_scan(16'h0000);
  endtask

  task automatic check_reset_outputs();
    check("rst_col_L",     {28'b0, col_L},     32'h0000000E);
    check("rst_key_code",  {28'b0, key_code},  32'h0);
    check("rst_key_valid", {31'b0, key_valid}, 32'h0);
    check("rst_key_held",  {31'b0, key_held},  32'h0);
    check("rst_digits",    {16'b0, digits},    32'h0);
  endtask

  // Monitor: every strobe must match the oldest expected acceptance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_L && key_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe actual=%h expected=no strobe", key_code);
        end else begin
          e = exp_q.pop_front();
          check("strobe_code",   {28'b0, key_code}, {28'b0, e.code});
          check("strobe_digits", {16'b0, digits},   {16'b0, e.dig});
        end
      end
    end
  end

  initial begin
    logic [3:0]  expc;
    logic [3:0]  cur;
    logic [15:0] pat;
    int          kind, i, j;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_L = 1'b1;

    // 1. Idle scanning: each column held for SCAN_DIV clocks
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      expc = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check("col_rotate", {28'b0, col_L}, {28'b0, expc});
    end
    check("idle_key_held", {31'b0, key_held}, 32'h0);

    // 2. Hold '5' for 5 scans, then release for 3
    repeat (5) run_scan(16'h0001 << 5);
    check("key5_code", {28'b0, key_code}, 32'h5);
    repeat (3) run_scan(16'h0000);

    // 3. '9' for 2 scans, gap, then 3 scans
    repeat (2) run_scan(16'h0001 << 10);
    run_scan(16'h0000);
    repeat (3) run_scan(16'h0001 << 10);
    check("key9_code", {28'b0, key_code}, 32'h9);
    repeat (3) run_scan(16'h0000);

    // 4. '1' and 'A' together: ghost rejection
    repeat (6) run_scan((16'h0001 << 0) | (16'h0001 << 3));
    check("multi_code_hold", {28'b0, key_code}, {28'b0, m_code});
    repeat (3) run_scan(16'h0000);

    // 5. Digit history: 1,2,3,4 then F
    press_release(0);
    press_release(1);
    press_release(2);
    press_release(4);
`ifdef KEYPAD_SHIFT_EN
    check("digits_1234", {16'b0, digits}, 32'h1234);
`else
    check("digits_plain4", {16'b0, digits}, 32'h0004);
`endif
    press_release(13);
`ifdef KEYPAD_SHIFT_EN
    check("digits_234F", {16'b0, digits}, 32'h234F);
`else
    check("digits_plainF", {16'b0, digits}, 32'h000F);
`endif

    // 6. Reset in the middle of debouncing 'D'
    run_scan(16'h0001 << 15);
    repeat (12) @(posedge clk);
    #1;
    rst_L = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_L = 1'b1;
    repeat (3) run_scan(16'h0001 << 15);
    check("keyD_code", {28'b0, key_code}, 32'hD);
    repeat (3) run_scan(16'h0000);

    // Random scans: mostly a repeated key, with gaps, ghosts and key changes
    cur = 4'($urandom_range(0, 15));
    for (int s = 0; s < 120; s++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 1) begin
        pat = 16'h0000;
      end else if (kind == 2) begin
        i = $urandom_range(0, 15);
        j = (i + 1 + $urandom_range(0, 14)) % 16;
        pat = (16'h0001 << i) | (16'h0001 << j);
      end else begin
        if (kind == 9) cur = 4'($urandom_range(0, 15));
        pat = 16'h0001 << cur;
      end
      run_scan(pat);
    end
    repeat (DB + 1) run_scan(16'h0000);
    check("final_code", {28'b0, key_code}, {28'b0, m_code});

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
